// File: rtl/forth_pkg.sv
// ---------------------------------------------------------------------------
// forth_pkg
// Shared definitions for the forth CPU core and its boot controller.
//   DEF_IADDR_W / DEF_IDATA_W : default instruction address / word widths,
//                               kept here so the CPU and the loader agree
//   BOOT_SYNC                 : frame start byte of the boot protocol
//   boot_state_t              : boot controller state encoding
//   count_in_range()          : checks a frame word count against the imem depth
// ---------------------------------------------------------------------------
package forth_pkg;

    localparam int DEF_IADDR_W = 10;
    localparam int DEF_IDATA_W = 16;

    localparam logic [7:0] BOOT_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        CNT_LO  = 3'd1,
        CNT_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        CSUM    = 3'd5,
        HOLD    = 3'd6,
        RUN     = 3'd7
    } boot_state_t;

    // A frame must carry at least one word and no more than the memory holds.
    function automatic logic count_in_range(input logic [15:0] cnt, input int depth);
        return (cnt != 16'd0) && ({16'd0, cnt} <= 32'(depth));
    endfunction

endpackage

// File: rtl/forth_boot_ctrl.sv
// ---------------------------------------------------------------------------
// forth_boot_ctrl
// Loads a program image from a byte stream into instruction memory and
// sequences the CPU reset around it.
//
// Frame: A5, CNT_LO, CNT_HI, N x (word_lo, word_hi), CSUM
//        CSUM is the XOR of every byte after the sync byte.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   rx_data    : incoming byte
//   rx_valid   : rx_data is valid
//   rx_ready   : byte accepted this cycle when rx_valid is also high
//                (combinational, low only while the CPU reset is being held)
//   imem_we    : one-cycle instruction memory write strobe
//   imem_waddr : write address (LOAD_BASE + word index, wraps)
//   imem_wdata : write data {hi, lo}
//   cpu_reset  : CPU reset, high until a verified image is released
//   boot_done  : high while the CPU runs a verified image
//   err        : last load failed; sticky until the next sync byte
// ---------------------------------------------------------------------------
module forth_boot_ctrl
    import forth_pkg::*;
#(
    parameter int IADDR_W    = DEF_IADDR_W,
    parameter int IDATA_W    = DEF_IDATA_W,
    parameter int IMEM_DEPTH = 1024,
    parameter int LOAD_BASE  = 0,
    parameter int RST_HOLD   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_waddr,
    output logic [IDATA_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               boot_done,
    output logic               err
);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    boot_state_t        r_state;
    logic [15:0]        r_count;     // word count of the current frame
    logic [15:0]        r_index;     // index of the next word to write
    logic [7:0]         r_lo;        // low byte of the word being assembled
    logic [7:0]         r_xor;       // running checksum
    logic [3:0]         r_hold;      // reset-hold countdown
    logic               r_imem_we;
    logic [IADDR_W-1:0] r_imem_waddr;
    logic [IDATA_W-1:0] r_imem_wdata;
    logic               r_cpu_reset;
    logic               r_boot_done;
    logic               r_err;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    boot_state_t        w_state_next;
    logic [15:0]        w_count_next;
    logic [15:0]        w_index_next;
    logic [7:0]         w_lo_next;
    logic [7:0]         w_xor_next;
    logic [3:0]         w_hold_next;
    logic               w_imem_we_next;
    logic [IADDR_W-1:0] w_imem_waddr_next;
    logic [IDATA_W-1:0] w_imem_wdata_next;
    logic               w_cpu_reset_next;
    logic               w_boot_done_next;
    logic               w_err_next;

    // -----------------------------------------------------------------------
    // Helper signals
    // -----------------------------------------------------------------------
    logic               w_accept;
    logic               w_is_sync;
    logic [15:0]        w_count_full;
    logic               w_count_ok;
    logic [7:0]         w_xor_acc;
    logic [IADDR_W-1:0] w_word_addr;
    logic [IDATA_W-1:0] w_word_data;
    logic               w_last_word;
    logic [15:0]        w_index_inc;

    // Only the reset-hold window refuses bytes; a byte presented then is
    // left pending and is taken in the first RUN cycle.
    assign rx_ready     = (r_state != HOLD);
    assign w_accept     = rx_valid && rx_ready;
    assign w_is_sync    = (rx_data == BOOT_SYNC);

    // The count is validated on the very edge that accepts its high byte,
    // so use the incoming byte rather than waiting for it to land in r_count.
    assign w_count_full = {rx_data, r_count[7:0]};
    assign w_count_ok   = count_in_range(w_count_full, IMEM_DEPTH);

    assign w_xor_acc    = r_xor ^ rx_data;
    assign w_index_inc  = r_index + 16'd1;
    assign w_last_word  = (w_index_inc == r_count);

    // Address arithmetic deliberately truncates: loads past the top of the
    // address space wrap to the bottom.
    assign w_word_addr  = IADDR_W'(32'(LOAD_BASE) + {16'd0, r_index});
    assign w_word_data  = IDATA_W'({rx_data, r_lo});

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_index_next      = r_index;
        w_lo_next         = r_lo;
        w_xor_next        = r_xor;
        w_hold_next       = r_hold;
        w_imem_we_next    = 1'b0;
        w_imem_waddr_next = r_imem_waddr;
        w_imem_wdata_next = r_imem_wdata;
        w_cpu_reset_next  = r_cpu_reset;
        w_boot_done_next  = r_boot_done;
        w_err_next        = r_err;

        case (r_state)
            SYNC: begin
                if (w_accept && w_is_sync) begin
                    w_err_next   = 1'b0;
                    w_xor_next   = 8'd0;
                    w_state_next = CNT_LO;
                end
            end

            CNT_LO: begin
                if (w_accept) begin
                    w_count_next = {r_count[15:8], rx_data};
                    w_xor_next   = w_xor_acc;
                    w_state_next = CNT_HI;
                end
            end

            CNT_HI: begin
                if (w_accept) begin
                    w_count_next = w_count_full;
                    w_xor_next   = w_xor_acc;
                    if (w_count_ok) begin
                        w_index_next = 16'd0;
                        w_state_next = DATA_LO;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = SYNC;
                    end
                end
            end

            DATA_LO: begin
                if (w_accept) begin
                    w_lo_next    = rx_data;
                    w_xor_next   = w_xor_acc;
                    w_state_next = DATA_HI;
                end
            end

            DATA_HI: begin
                if (w_accept) begin
                    // Words go to imem before the checksum is known; the CPU
                    // is held in reset, so a bad image is never executed.
                    w_xor_next        = w_xor_acc;
                    w_imem_we_next    = 1'b1;
                    w_imem_waddr_next = w_word_addr;
                    w_imem_wdata_next = w_word_data;
                    w_index_next      = w_index_inc;
                    w_state_next      = w_last_word ? CSUM : DATA_LO;
                end
            end

            CSUM: begin
                if (w_accept) begin
                    if (rx_data == r_xor) begin
                        w_hold_next  = 4'(RST_HOLD);
                        w_state_next = HOLD;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = SYNC;
                    end
                end
            end

            HOLD: begin
                // Release on the edge that would take the counter to zero so
                // cpu_reset is high for exactly RST_HOLD cycles after CSUM.
                if (r_hold <= 4'd1) begin
                    w_hold_next      = 4'd0;
                    w_cpu_reset_next = 1'b0;
                    w_boot_done_next = 1'b1;
                    w_state_next     = RUN;
                end else begin
                    w_hold_next = r_hold - 4'd1;
                end
            end

            RUN: begin
                // A sync byte while running pulls the CPU back into reset and
                // restarts the load without needing a system reset.
                if (w_accept && w_is_sync) begin
                    w_cpu_reset_next = 1'b1;
                    w_boot_done_next = 1'b0;
                    w_err_next       = 1'b0;
                    w_xor_next       = 8'd0;
                    w_state_next     = CNT_LO;
                end
            end

            default: begin
                w_state_next = SYNC;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SYNC;
            r_count      <= 16'd0;
            r_index      <= 16'd0;
            r_lo         <= 8'd0;
            r_xor        <= 8'd0;
            r_hold       <= 4'd0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= IADDR_W'(LOAD_BASE);
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_boot_done  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_index      <= w_index_next;
            r_lo         <= w_lo_next;
            r_xor        <= w_xor_next;
            r_hold       <= w_hold_next;
            r_imem_we    <= w_imem_we_next;
            r_imem_waddr <= w_imem_waddr_next;
            r_imem_wdata <= w_imem_wdata_next;
            r_cpu_reset  <= w_cpu_reset_next;
            r_boot_done  <= w_boot_done_next;
            r_err        <= w_err_next;
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign boot_done  = r_boot_done;
    assign err        = r_err;

endmodule

// File: doc/forth_boot_ctrl.md
Name: forth_boot_ctrl

Overview:
Boot/sequencing controller for the forth CPU core. It receives a program image over a byte-stream valid/ready link (UART RX or debug host) and writes it into instruction memory through a dedicated write port. It holds the CPU in reset while loading, then releases it once the checksum passes. A new sync byte while the CPU runs forces it back into reset and restarts the load, so images can be reloaded without a system reset.

Parameters:
IADDR_W, 10, instruction address width (matches CPU iaddr)
IDATA_W, 16, instruction word width
IMEM_DEPTH, 1024, maximum words per image
LOAD_BASE, 0, imem address of the first loaded word
RST_HOLD, 4, cycles cpu_reset stays high after a good image (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  controller accepts a byte this cycle
imem_we  out  1  instruction memory write strobe
imem_waddr  out  IADDR_W  write address
imem_wdata  out  IDATA_W  write data
cpu_reset  out  1  drives the CPU reset input
boot_done  out  1  high while the CPU runs a verified image
err  out  1  last load failed; sticky until the next sync byte

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state=SYNC, cpu_reset=1, imem_we=0, imem_waddr=LOAD_BASE, imem_wdata=0, boot_done=0, err=0. All outputs are registered except rx_ready.
- A byte is accepted on a posedge where rx_valid&&rx_ready.
- rx_ready=1 in every state except HOLD.
- Frame format: 0xA5 (sync), CNT_LO, CNT_HI, then N words sent low byte first, then CSUM.
  - The 16-bit count field must be 1..IMEM_DEPTH.
  - CSUM = XOR of all bytes after sync: the count bytes and all payload bytes.
- States:
  - SYNC: discard bytes until 0xA5 is accepted. On 0xA5: clear err and the running XOR, go to CNT_LO.
  - CNT_LO / CNT_HI: latch the count and XOR each byte. After CNT_HI is accepted, an invalid count (0 or >IMEM_DEPTH) gives err=1 and a return to SYNC on the next edge. A valid count goes to DATA_LO with word index 0.
  - DATA_LO: latch the low byte, XOR it, go to DATA_HI.
  - DATA_HI: on acceptance, XOR the byte; next cycle imem_we=1 for exactly one cycle, with imem_waddr=LOAD_BASE+index and imem_wdata={hi,lo}. The index increments. The last word goes to CSUM, otherwise back to DATA_LO.
  - Back-to-back words sustain one word per 2 accepted bytes with no stall.
  - CSUM: if the byte matches the XOR, load the counter with RST_HOLD and go to HOLD. On mismatch, err=1 and go to SYNC, with cpu_reset still 1.
  - HOLD: cpu_reset=1 and the counter decrements. At 0, go to RUN. The cycle after HOLD exits, cpu_reset=0 and boot_done=1.
  - RUN: bytes are consumed and ignored except 0xA5. On 0xA5: next cycle cpu_reset=1 and boot_done=0, err clears, go to CNT_LO.
- Words are written to imem before the checksum is verified. This is safe because the CPU stays in reset, and a bad image is never released.
- Address arithmetic wraps modulo 2^IADDR_W when LOAD_BASE+N exceeds the depth. Wrap is not an error.
- rx_valid high with rx_ready low (HOLD) is not consumed; the byte is taken once RUN is entered.
- Reset asserted mid-frame aborts immediately with the reset values above; the partial image is abandoned.

Decomposition:
- forth_pkg holds:
  - boot_state_t enum (SYNC, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CSUM, HOLD, RUN)
  - constant BOOT_SYNC=8'hA5
  - IADDR_W/IDATA_W defaults, shared with the CPU
- No sub-module. The byte-pair assembly and checksum are small enough to stay inline in one always_ff plus a combinational next-state block.

Test Plan:
- Reset, then drop reset: cpu_reset=1, boot_done=0, err=0, imem_we=0; rx_ready=1 in the first cycle after reset.
- Send A5 02 00 01 00 07 E0 E4: imem_we pulses write addr0=0001 and addr1=E007. After the E4 byte, cpu_reset stays 1 for 4 cycles then drops; boot_done=1, err=0.
- Same frame with CSUM=00: both words are written, err=1, cpu_reset stays 1, boot_done=0. A following byte 0x55 is ignored and the state remains SYNC.
- Send A5 00 00: err=1 after CNT_HI, no imem_we, and the next A5 restarts cleanly.
- After a good boot, send 12 then A5: 12 is ignored. After A5 is accepted, cpu_reset=1 and boot_done=0 next cycle, and a 1-word frame reloads addr0 and re-releases.
- Assert reset asynchronously between a DATA_LO and a DATA_HI byte: outputs go to reset values within the same cycle. The next frame writes starting at LOAD_BASE.
